// File: rtl/id_ex_stage_pkg.sv
// ALU definitions shared by the ID/EX stage and the ALU: control codes,
// ALUOp encodings, R-type funct values and the ALUOp/funct decoder.
package id_ex_stage_pkg;

   typedef enum logic [2:0] {
      ALU_AND = 3'b000,
      ALU_OR  = 3'b001,
      ALU_ADD = 3'b010,
      ALU_MUL = 3'b011,
      ALU_SUB = 3'b110
   } alu_ctrl_e;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_RTYPE = 2'b10,
      ALUOP_OR    = 2'b11
   } alu_op_e;

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_MUL = 6'b011000;

   typedef struct packed {
      alu_ctrl_e ctrl;
      logic      unsupported;
   } alu_dec_t;

   // Unsupported R-type funct values fall back to ADD so the ALU stays benign.
   function automatic alu_dec_t alu_decode(input logic [1:0] aluop, input logic [5:0] funct);
      alu_dec_t d;
      d.ctrl        = ALU_ADD;
      d.unsupported = 1'b0;
      case (aluop)
         ALUOP_ADD: d.ctrl = ALU_ADD;
         ALUOP_SUB: d.ctrl = ALU_SUB;
         ALUOP_OR:  d.ctrl = ALU_OR;
         default: begin
            case (funct)
               FUNCT_ADD: d.ctrl = ALU_ADD;
               FUNCT_SUB: d.ctrl = ALU_SUB;
               FUNCT_AND: d.ctrl = ALU_AND;
               FUNCT_OR:  d.ctrl = ALU_OR;
               FUNCT_MUL: d.ctrl = ALU_MUL;
               default: begin
                  d.ctrl        = ALU_ADD;
                  d.unsupported = 1'b1;
               end
            endcase
         end
      endcase
      return d;
   endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Bus between decode, the ID/EX register, the later pipe stages (forwarding
// sources) and the ALU. The stage is the slave; the surrounding pipeline is the master.
interface id_ex_stage_if #(
   parameter int DW = 32,
   parameter int AW = 5
);
   import id_ex_stage_pkg::*;

   logic          valid_i;
   logic          RegWrite_i;
   logic          ALUSrc_i;
   logic [1:0]    ALUOp_i;
   logic [5:0]    funct_i;
   logic [DW-1:0] rs_data_i;
   logic [DW-1:0] rt_data_i;
   logic [DW-1:0] imm_i;
   logic [AW-1:0] rs_addr_i;
   logic [AW-1:0] rt_addr_i;
   logic [AW-1:0] rd_addr_i;

   logic          exmem_RegWrite_i;
   logic [AW-1:0] exmem_rd_i;
   logic [DW-1:0] exmem_data_i;
   logic          memwb_RegWrite_i;
   logic [AW-1:0] memwb_rd_i;
   logic [DW-1:0] memwb_data_i;

   logic [DW-1:0] data1_o;
   logic [DW-1:0] data2_o;
   logic [2:0]    ALUCtrl_o;
   logic          valid_o;
   logic          RegWrite_o;
   logic [AW-1:0] rd_addr_o;
   logic          illegal_o;

   modport master (
      output valid_i, RegWrite_i, ALUSrc_i, ALUOp_i, funct_i,
             rs_data_i, rt_data_i, imm_i, rs_addr_i, rt_addr_i, rd_addr_i,
             exmem_RegWrite_i, exmem_rd_i, exmem_data_i,
             memwb_RegWrite_i, memwb_rd_i, memwb_data_i,
      input  data1_o, data2_o, ALUCtrl_o, valid_o, RegWrite_o, rd_addr_o, illegal_o
   );

   modport slave (
      input  valid_i, RegWrite_i, ALUSrc_i, ALUOp_i, funct_i,
             rs_data_i, rt_data_i, imm_i, rs_addr_i, rt_addr_i, rd_addr_i,
             exmem_RegWrite_i, exmem_rd_i, exmem_data_i,
             memwb_RegWrite_i, memwb_rd_i, memwb_data_i,
      output data1_o, data2_o, ALUCtrl_o, valid_o, RegWrite_o, rd_addr_o, illegal_o
   );

endinterface

// File: rtl/id_ex_stage_fwd_unit.sv
// Per-operand forwarding select. The nearer EX/MEM result beats MEM/WB;
// register 0 is hard-wired zero and is never forwarded.
module id_ex_stage_fwd_unit #(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic [AW-1:0] i_reg_addr,
   input  logic [DW-1:0] i_reg_data,
   input  logic          i_exmem_we,
   input  logic [AW-1:0] i_exmem_rd,
   input  logic [DW-1:0] i_exmem_data,
   input  logic          i_memwb_we,
   input  logic [AW-1:0] i_memwb_rd,
   input  logic [DW-1:0] i_memwb_data,
   output logic [DW-1:0] o_data
);

   logic w_nonzero;
   logic w_hit_exmem;
   logic w_hit_memwb;

   assign w_nonzero   = (i_reg_addr != '0);
   assign w_hit_exmem = w_nonzero && i_exmem_we && (i_exmem_rd == i_reg_addr);
   assign w_hit_memwb = w_nonzero && i_memwb_we && (i_memwb_rd == i_reg_addr);

   // Priority mux: EX/MEM, then MEM/WB, then the latched register-file value.
   always_comb begin
      o_data = i_reg_data;
      if (w_hit_exmem)      o_data = i_exmem_data;
      else if (w_hit_memwb) o_data = i_memwb_data;
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register. Latches decoded operands and control, decodes the
// ALU control code at capture, and forwards later-stage results onto the ALU
// operands combinationally from the latched register indices.
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           stall_i,
   input  logic           flush_i,
   id_ex_stage_if.slave   bus
);

   logic          r_valid;
   logic          r_regwrite;
   logic          r_alusrc;
   alu_ctrl_e     r_aluctrl;
   logic          r_illegal;
   logic [DW-1:0] r_rs_data;
   logic [DW-1:0] r_rt_data;
   logic [DW-1:0] r_imm;
   logic [AW-1:0] r_rs_addr;
   logic [AW-1:0] r_rt_addr;
   logic [AW-1:0] r_rd_addr;

   alu_dec_t      w_dec;
   logic [DW-1:0] w_fwd_rs;
   logic [DW-1:0] w_fwd_rt;

   assign w_dec = alu_decode(bus.ALUOp_i, bus.funct_i);

   // Stage register update: reset, then flush (bubble), then stall (hold), then capture.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_valid    <= 1'b0;
         r_regwrite <= 1'b0;
         r_alusrc   <= 1'b0;
         r_aluctrl  <= ALU_AND;
         r_illegal  <= 1'b0;
         r_rs_data  <= '0;
         r_rt_data  <= '0;
         r_imm      <= '0;
         r_rs_addr  <= '0;
         r_rt_addr  <= '0;
         r_rd_addr  <= '0;
      end else if (flush_i) begin
         r_valid    <= 1'b0;
         r_regwrite <= 1'b0;
         r_alusrc   <= 1'b0;
         r_aluctrl  <= ALU_ADD;
         r_illegal  <= 1'b0;
         r_rs_data  <= '0;
         r_rt_data  <= '0;
         r_imm      <= '0;
         r_rs_addr  <= '0;
         r_rt_addr  <= '0;
         r_rd_addr  <= '0;
      end else if (!stall_i) begin
         r_valid    <= bus.valid_i;
         r_regwrite <= bus.RegWrite_i & bus.valid_i;
         r_alusrc   <= bus.ALUSrc_i;
         r_aluctrl  <= w_dec.ctrl;
         r_illegal  <= w_dec.unsupported & bus.valid_i;
         r_rs_data  <= bus.rs_data_i;
         r_rt_data  <= bus.rt_data_i;
         r_imm      <= bus.imm_i;
         r_rs_addr  <= bus.rs_addr_i;
         r_rt_addr  <= bus.rt_addr_i;
         r_rd_addr  <= bus.rd_addr_i;
      end
   end

   id_ex_stage_fwd_unit #(.DW(DW), .AW(AW)) u_fwd_rs (
      .i_reg_addr   (r_rs_addr),
      .i_reg_data   (r_rs_data),
      .i_exmem_we   (bus.exmem_RegWrite_i),
      .i_exmem_rd   (bus.exmem_rd_i),
      .i_exmem_data (bus.exmem_data_i),
      .i_memwb_we   (bus.memwb_RegWrite_i),
      .i_memwb_rd   (bus.memwb_rd_i),
      .i_memwb_data (bus.memwb_data_i),
      .o_data       (w_fwd_rs)
   );

   id_ex_stage_fwd_unit #(.DW(DW), .AW(AW)) u_fwd_rt (
      .i_reg_addr   (r_rt_addr),
      .i_reg_data   (r_rt_data),
      .i_exmem_we   (bus.exmem_RegWrite_i),
      .i_exmem_rd   (bus.exmem_rd_i),
      .i_exmem_data (bus.exmem_data_i),
      .i_memwb_we   (bus.memwb_RegWrite_i),
      .i_memwb_rd   (bus.memwb_rd_i),
      .i_memwb_data (bus.memwb_data_i),
      .o_data       (w_fwd_rt)
   );

   assign bus.data1_o    = w_fwd_rs;
   assign bus.data2_o    = r_alusrc ? r_imm : w_fwd_rt;
   assign bus.ALUCtrl_o  = r_aluctrl;
   assign bus.valid_o    = r_valid;
   assign bus.RegWrite_o = r_regwrite;
   assign bus.rd_addr_o  = r_rd_addr;
   assign bus.illegal_o  = r_illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for the ID/EX stage: reset, decode table, forwarding priority,
// ALUSrc select, stall/flush and illegal-funct flagging.
module tb_id_ex_stage;

   logic clk = 1'b0;
   logic rst;
   logic stall;
   logic flush;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   id_ex_stage_if #(.DW(32), .AW(5)) bus ();

   id_ex_stage #(.DW(32), .AW(5)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .stall_i (stall),
      .flush_i (flush),
      .bus     (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      bus.valid_i          = 1'b0;
      bus.RegWrite_i       = 1'b0;
      bus.ALUSrc_i         = 1'b0;
      bus.ALUOp_i          = 2'b00;
      bus.funct_i          = 6'b0;
      bus.rs_data_i        = '0;
      bus.rt_data_i        = '0;
      bus.imm_i            = '0;
      bus.rs_addr_i        = '0;
      bus.rt_addr_i        = '0;
      bus.rd_addr_i        = '0;
      bus.exmem_RegWrite_i = 1'b0;
      bus.exmem_rd_i       = '0;
      bus.exmem_data_i     = '0;
      bus.memwb_RegWrite_i = 1'b0;
      bus.memwb_rd_i       = '0;
      bus.memwb_data_i     = '0;
   endtask

   task automatic drive_instr(input logic [1:0] op, input logic [5:0] fn,
                              input logic [4:0] rsa, input logic [31:0] rsd,
                              input logic [4:0] rta, input logic [31:0] rtd,
                              input logic [4:0] rda);
      bus.valid_i    = 1'b1;
      bus.RegWrite_i = 1'b1;
      bus.ALUSrc_i   = 1'b0;
      bus.ALUOp_i    = op;
      bus.funct_i    = fn;
      bus.rs_addr_i  = rsa;
      bus.rs_data_i  = rsd;
      bus.rt_addr_i  = rta;
      bus.rt_data_i  = rtd;
      bus.rd_addr_i  = rda;
   endtask

   task automatic test_reset();
      drive_idle();
      drive_instr(2'b10, 6'b100010, 5'd1, 32'h55, 5'd2, 32'h66, 5'd7);
      stall = 1'b0;
      flush = 1'b0;
      rst   = 1'b1;
      tick();
      tick();
      n_vec++; if (bus.valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.valid_o); end
      n_vec++; if (bus.RegWrite_o !== 1'b0) begin n_err++; $display("FAIL reset_regwrite: got %b want 0", bus.RegWrite_o); end
      n_vec++; if (bus.ALUCtrl_o !== 3'b000) begin n_err++; $display("FAIL reset_aluctrl: got %b want 000", bus.ALUCtrl_o); end
      n_vec++; if (bus.illegal_o !== 1'b0) begin n_err++; $display("FAIL reset_illegal: got %b want 0", bus.illegal_o); end
      n_vec++; if (bus.rd_addr_o !== 5'd0) begin n_err++; $display("FAIL reset_rd: got %0d want 0", bus.rd_addr_o); end
      n_vec++; if (bus.data1_o !== 32'h0 || bus.data2_o !== 32'h0) begin
         n_err++; $display("FAIL reset_data: got %h/%h want 0/0", bus.data1_o, bus.data2_o); end
      rst = 1'b0;
   endtask

   task automatic test_rtype_sub();
      drive_idle();
      drive_instr(2'b10, 6'b100010, 5'd1, 32'd7, 5'd2, 32'd3, 5'd9);
      tick();
      n_vec++; if (bus.ALUCtrl_o !== 3'b110) begin n_err++; $display("FAIL sub_aluctrl: got %b want 110", bus.ALUCtrl_o); end
      n_vec++; if (bus.data1_o !== 32'd7) begin n_err++; $display("FAIL sub_data1: got %h want 7", bus.data1_o); end
      n_vec++; if (bus.data2_o !== 32'd3) begin n_err++; $display("FAIL sub_data2: got %h want 3", bus.data2_o); end
      n_vec++; if (bus.valid_o !== 1'b1 || bus.RegWrite_o !== 1'b1) begin
         n_err++; $display("FAIL sub_valid_rw: got %b/%b want 1/1", bus.valid_o, bus.RegWrite_o); end
      n_vec++; if (bus.rd_addr_o !== 5'd9) begin n_err++; $display("FAIL sub_rd: got %0d want 9", bus.rd_addr_o); end
      n_vec++; if (bus.illegal_o !== 1'b0) begin n_err++; $display("FAIL sub_illegal: got %b want 0", bus.illegal_o); end
   endtask

   task automatic test_decode();
      logic [1:0] ops [9] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00};
      logic [5:0] fns [9] = '{6'b000000, 6'b000000, 6'b000000, 6'b100000, 6'b100100,
                              6'b100101, 6'b011000, 6'b111111, 6'b101010};
      logic [2:0] ctl [9] = '{3'b010, 3'b110, 3'b001, 3'b010, 3'b000, 3'b001, 3'b011, 3'b010, 3'b010};
      logic       ill [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      drive_idle();
      for (int i = 0; i < 9; i++) begin
         drive_instr(ops[i], fns[i], 5'd1, 32'h10, 5'd2, 32'h20, 5'd3);
         tick();
         n_vec++; if (bus.ALUCtrl_o !== ctl[i] || bus.illegal_o !== ill[i]) begin
            n_err++;
            $display("FAIL decode[%0d] op=%b fn=%b: got ctrl=%b ill=%b want ctrl=%b ill=%b",
                     i, ops[i], fns[i], bus.ALUCtrl_o, bus.illegal_o, ctl[i], ill[i]);
         end
      end
   endtask

   task automatic test_forward();
      drive_idle();
      drive_instr(2'b00, 6'b0, 5'd5, 32'h11, 5'd6, 32'h66, 5'd8);
      tick();
      bus.valid_i          = 1'b0;
      bus.exmem_RegWrite_i = 1'b1; bus.exmem_rd_i = 5'd5; bus.exmem_data_i = 32'hAA;
      bus.memwb_RegWrite_i = 1'b1; bus.memwb_rd_i = 5'd5; bus.memwb_data_i = 32'hBB;
      #1;
      n_vec++; if (bus.data1_o !== 32'hAA) begin n_err++; $display("FAIL fwd_both: got %h want aa", bus.data1_o); end
      n_vec++; if (bus.data2_o !== 32'h66) begin n_err++; $display("FAIL fwd_rt_nohit: got %h want 66", bus.data2_o); end
      bus.exmem_RegWrite_i = 1'b0;
      #1;
      n_vec++; if (bus.data1_o !== 32'hBB) begin n_err++; $display("FAIL fwd_memwb: got %h want bb", bus.data1_o); end
      bus.memwb_RegWrite_i = 1'b0;
      #1;
      n_vec++; if (bus.data1_o !== 32'h11) begin n_err++; $display("FAIL fwd_none: got %h want 11", bus.data1_o); end
      bus.exmem_RegWrite_i = 1'b1; bus.exmem_rd_i = 5'd6; bus.exmem_data_i = 32'hCC;
      #1;
      n_vec++; if (bus.data2_o !== 32'hCC || bus.data1_o !== 32'h11) begin
         n_err++; $display("FAIL fwd_rt_exmem: got %h/%h want 11/cc", bus.data1_o, bus.data2_o); end
      drive_idle();
      drive_instr(2'b00, 6'b0, 5'd0, 32'h22, 5'd0, 32'h33, 5'd1);
      tick();
      bus.exmem_RegWrite_i = 1'b1; bus.exmem_rd_i = 5'd0; bus.exmem_data_i = 32'hAA;
      bus.memwb_RegWrite_i = 1'b1; bus.memwb_rd_i = 5'd0; bus.memwb_data_i = 32'hBB;
      #1;
      n_vec++; if (bus.data1_o !== 32'h22 || bus.data2_o !== 32'h33) begin
         n_err++; $display("FAIL fwd_r0: got %h/%h want 22/33", bus.data1_o, bus.data2_o); end
   endtask

   task automatic test_alusrc();
      drive_idle();
      drive_instr(2'b00, 6'b0, 5'd4, 32'h1, 5'd6, 32'h2, 5'd6);
      bus.ALUSrc_i = 1'b1;
      bus.imm_i    = 32'hFFFF_FFFC;
      tick();
      bus.exmem_RegWrite_i = 1'b1; bus.exmem_rd_i = 5'd6; bus.exmem_data_i = 32'hDEAD;
      #1;
      n_vec++; if (bus.data2_o !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL alusrc_imm: got %h want fffffffc", bus.data2_o); end
   endtask

   task automatic test_stall_flush();
      drive_idle();
      drive_instr(2'b01, 6'b0, 5'd3, 32'h100, 5'd2, 32'h200, 5'd4);
      tick();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive_instr(2'b11, 6'b100100, 5'd9, 32'h900 + i, 5'd10, 32'hA00 + i, 5'd12 + 5'(i));
         bus.valid_i = i[0];
         tick();
         n_vec++; if (bus.ALUCtrl_o !== 3'b110 || bus.rd_addr_o !== 5'd4 || bus.valid_o !== 1'b1 ||
                     bus.data1_o !== 32'h100 || bus.data2_o !== 32'h200) begin
            n_err++;
            $display("FAIL stall_hold[%0d]: got ctrl=%b rd=%0d v=%b d1=%h d2=%h want 110/4/1/100/200",
                     i, bus.ALUCtrl_o, bus.rd_addr_o, bus.valid_o, bus.data1_o, bus.data2_o);
         end
      end
      bus.exmem_RegWrite_i = 1'b1; bus.exmem_rd_i = 5'd3; bus.exmem_data_i = 32'h777;
      #1;
      n_vec++; if (bus.data1_o !== 32'h777) begin n_err++; $display("FAIL stall_fwd: got %h want 777", bus.data1_o); end
      flush = 1'b1;
      tick();
      n_vec++; if (bus.valid_o !== 1'b0 || bus.RegWrite_o !== 1'b0 || bus.ALUCtrl_o !== 3'b010 || bus.illegal_o !== 1'b0) begin
         n_err++;
         $display("FAIL flush_stall: got v=%b rw=%b ctrl=%b ill=%b want 0/0/010/0",
                  bus.valid_o, bus.RegWrite_o, bus.ALUCtrl_o, bus.illegal_o);
      end
      flush = 1'b0;
      stall = 1'b0;
   endtask

   task automatic test_illegal();
      drive_idle();
      drive_instr(2'b10, 6'b101010, 5'd1, 32'h1, 5'd2, 32'h2, 5'd3);
      tick();
      n_vec++; if (bus.ALUCtrl_o !== 3'b010 || bus.illegal_o !== 1'b1) begin
         n_err++; $display("FAIL illegal_valid: got ctrl=%b ill=%b want 010/1", bus.ALUCtrl_o, bus.illegal_o); end
      bus.valid_i = 1'b0;
      tick();
      n_vec++; if (bus.illegal_o !== 1'b0 || bus.valid_o !== 1'b0 || bus.RegWrite_o !== 1'b0 || bus.ALUCtrl_o !== 3'b010) begin
         n_err++;
         $display("FAIL illegal_invalid: got ill=%b v=%b rw=%b ctrl=%b want 0/0/0/010",
                  bus.illegal_o, bus.valid_o, bus.RegWrite_o, bus.ALUCtrl_o);
      end
   endtask

   task automatic test_back_to_back();
      drive_idle();
      drive_instr(2'b11, 6'b0, 5'd1, 32'hA1, 5'd2, 32'hB2, 5'd21);
      tick();
      drive_instr(2'b10, 6'b011000, 5'd3, 32'hC3, 5'd4, 32'hD4, 5'd22);
      bus.RegWrite_i = 1'b0;
      n_vec++; if (bus.ALUCtrl_o !== 3'b001 || bus.data1_o !== 32'hA1 || bus.rd_addr_o !== 5'd21) begin
         n_err++; $display("FAIL b2b_first: got ctrl=%b d1=%h rd=%0d want 001/a1/21", bus.ALUCtrl_o, bus.data1_o, bus.rd_addr_o); end
      tick();
      n_vec++; if (bus.ALUCtrl_o !== 3'b011 || bus.data2_o !== 32'hD4 || bus.rd_addr_o !== 5'd22 || bus.RegWrite_o !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_second: got ctrl=%b d2=%h rd=%0d rw=%b want 011/d4/22/0",
                  bus.ALUCtrl_o, bus.data2_o, bus.rd_addr_o, bus.RegWrite_o);
      end
   endtask

   initial begin
      rst   = 1'b1;
      stall = 1'b0;
      flush = 1'b0;
      drive_idle();
      test_reset();
      test_rtype_sub();
      test_decode();
      test_forward();
      test_alusrc();
      test_stall_flush();
      test_illegal();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
